// File: rtl/comb_decimator.sv
// CIC comb section: decimates a wrapping accumulator stream by r, then applies
// s cascaded comb stages y[k] = x[k] - x[k-d] with modulo-2^n arithmetic.

module comb_decimator #(
  parameter int n = 17,
  parameter int s = 1,
  parameter int r = 4,
  parameter int d = 1
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                ce,
  input  logic signed [n-1:0] in,
  output logic signed [n-1:0] out,
  output logic                ovalid,
  output logic                primed
);

  localparam int cw = (r > 1) ? $clog2(r) : 1;
  localparam int wd = s * d;
  localparam int ww = $clog2(wd + 1);

  generate
    if (n < 1) begin : g_bad_n
      $error("comb_decimator: n must be at least 1");
    end
    if ((s < 1) || (s > 8)) begin : g_bad_s
      $error("comb_decimator: s must be in 1..8");
    end
    if ((r < 1) || (r > 256)) begin : g_bad_r
      $error("comb_decimator: r must be in 1..256");
    end
    if ((d < 1) || (d > 4)) begin : g_bad_d
      $error("comb_decimator: d must be in 1..4");
    end
  endgenerate

  // Wrapping difference; the integrator upstream relies on this overflow.
  function automatic logic signed [n-1:0] mod_sub(input logic signed [n-1:0] a,
                                                  input logic signed [n-1:0] b);
    return a - b;
  endfunction

  logic [cw-1:0]       cnt_r;
  logic                cap_s;
  logic [s-1:0]        stb_s;
  logic [s-1:0]        pipe_r;
  logic signed [n-1:0] x_s     [s];
  logic signed [n-1:0] stage_r [s];
  logic signed [n-1:0] tap_r   [s][d];
  logic [ww-1:0]       wcnt_r;
  logic                primed_r;

  // Capture strobe: last enabled sample of each group of r.
  always_comb begin
    cap_s = 1'b0;
    if (ce && (cnt_r == cw'(r - 1))) begin
      cap_s = 1'b1;
    end else begin
      cap_s = 1'b0;
    end
  end

  // Decimation counter, frozen while ce is low.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_r <= {cw{1'b0}};
    end else if (cap_s) begin
      cnt_r <= {cw{1'b0}};
    end else if (ce) begin
      cnt_r <= cnt_r + cw'(1);
    end
  end

  // Per-stage input data and strobes; stage k+1 runs one clk behind stage k.
  always_comb begin
    stb_s    = {s{1'b0}};
    stb_s[0] = cap_s;
    x_s[0]   = in;
    for (int k = 1; k < s; k++) begin
      stb_s[k] = pipe_r[k-1];
      x_s[k]   = stage_r[k-1];
    end
  end

  // Comb stages and strobe pipeline; data moves only on strobes.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pipe_r <= {s{1'b0}};
      for (int k = 0; k < s; k++) begin
        stage_r[k] <= {n{1'b0}};
        for (int j = 0; j < d; j++) begin
          tap_r[k][j] <= {n{1'b0}};
        end
      end
    end else begin
      pipe_r <= stb_s;
      for (int k = 0; k < s; k++) begin
        if (stb_s[k]) begin
          stage_r[k]  <= mod_sub(x_s[k], tap_r[k][d-1]);
          tap_r[k][0] <= x_s[k];
          for (int j = 1; j < d; j++) begin
            tap_r[k][j] <= tap_r[k][j-1];
          end
        end
      end
    end
  end

  // Warm-up: primed rises with the output emitted after s*d earlier ones.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wcnt_r   <= {ww{1'b0}};
      primed_r <= 1'b0;
    end else if (stb_s[s-1]) begin
      if (wcnt_r == ww'(wd)) begin
        primed_r <= 1'b1;
      end else begin
        wcnt_r <= wcnt_r + ww'(1);
      end
    end
  end

  assign out    = stage_r[s-1];
  assign ovalid = pipe_r[s-1];
  assign primed = primed_r;

  comb_decimator_chk u_chk (
    .clk    (clk),
    .clr    (clr),
    .ovalid (ovalid),
    .primed (primed)
  );

endmodule

// Property checks for comb_decimator output handshake.
module comb_decimator_chk (
  input logic clk,
  input logic clr,
  input logic ovalid,
  input logic primed
);

  ap_primed_sticky: assert property (@(posedge clk) disable iff (clr) primed |=> primed);
  ap_primed_rise:   assert property (@(posedge clk) disable iff (clr) $rose(primed) |-> ovalid);

endmodule
